crc_4_check: RTL and testbench
==============================

// Module: crc_4_check
// PURPOSE
// Receive-side CRC checker paired with the 4-bit-per-clock CRC generator, polynomial G = 4'b1001 (x^3+1).
// - Frame format: one or more payload nibbles, then one trailer nibble {1'b0, R}.
// - R is the generator's remainder after it is fed the payload followed by one 4'h0 nibble.
// - The block consumes one nibble per accepted cycle, runs the same nibble-serial division, and reports pass/fail per frame.
// - It sits between the nibble deserializer and the frame consumer.
// PARAMETERS
// MAX_NIBBLES  64  maximum nibbles per frame, trailer included (legal range 2..255)
// CNT_W        8   width of the nibble counter; must satisfy 2**CNT_W > MAX_NIBBLES
// PORTS
// clk        in   1  rising-edge clock
// reset_n    in   1  asynchronous active-low reset
// in_valid   in   1  in_data/in_last valid
// in_ready   out  1  block can accept a nibble
// in_data    in   4  frame nibble, MSB-first bit order
// in_last    in   1  marks the trailer nibble (last nibble of frame)
// out_valid  out  1  per-frame result valid
// out_ready  in   1  consumer accepts result
// crc_ok     out  1  frame passed (remainder 0, trailer[3]==0, length legal)
// crc_err    out  1  frame failed (any cause); crc_ok and crc_err are never both 1
// len_err    out  1  failure cause: length illegal (1 nibble, or exceeds MAX_NIBBLES)
// rem_out    out  3  final remainder of the frame (0 on len_err)
// BEHAVIOUR
// - Reset (reset_n=0, async): state=IDLE, rem=0, count=0.
//   All outputs 0 except in_ready, which resets to 1.
// - Handshake: a nibble is accepted when in_valid & in_ready; a result is taken when out_valid & out_ready.
//   in_ready = !out_valid | out_ready, so frames may run back-to-back.
// - Division per accepted nibble: rem_next = ({rem,nibble} mod G)[2:0].
//   This is the same 4-stage XOR chain as the generator, computed combinationally in the same cycle.
//   rem clears to 0 at the start of every frame.
// - FSM states: IDLE, RUN, DROP.
//   IDLE: first accepted nibble -> rem_next, count=1.
//     in_last also set -> result len_err=1, crc_err=1; stay IDLE.
//     Otherwise -> RUN.
//   RUN: each accepted nibble updates rem, count+1.
//     in_last set -> result; crc_ok = (rem_next==0) & !in_data[3]; crc_err = !crc_ok; -> IDLE.
//     count reaches MAX_NIBBLES without in_last -> result len_err=1, crc_err=1; -> DROP.
//   DROP: accept and discard nibbles; in_last -> IDLE with no further result.
// - Result latency: out_valid rises the cycle after the terminating nibble is accepted.
//   Result outputs hold stable until taken.
//   If a new result is produced in the same cycle the old one is taken, the new one loads and out_valid stays 1.
// - A result is never dropped; with out_valid=1 and out_ready=0, input stalls (in_ready=0).
// - Reset mid-frame discards the partial frame and any pending result.
// CONFIGURATION
// CRC_CHECK_STATS_EN: when defined, the block adds these ports:
// - stat_good (out, 16): saturating count of crc_ok results taken.
// - stat_bad (out, 16): saturating count of crc_err results taken.
// - stat_clr (in, 1): synchronous clear; wins over an increment in the same cycle.
// - The counters reset to 0 and saturate at 16'hFFFF.
// - When undefined, these ports and counters do not exist; all other behaviour is identical.
// TESTING
// T1 good frame: nibbles 5,3(last) -> out_valid next cycle, crc_ok=1, rem_out=3'b000.
// T2 corrupted: nibbles F,0,2(last) -> crc_err=1, rem_out=3'b001; nibbles F,0,3(last) -> crc_ok=1.
// T3 trailer bit3 set: 5,B(last) -> crc_err=1, len_err=0, rem_out=3'b001.
// T4 length: single nibble 5(last) -> len_err=1.
//    MAX_NIBBLES+3 nibbles -> one len_err result, trailing nibbles dropped, next frame 5,3 passes.
// T5 backpressure: out_ready=0 after T1 -> in_ready=0 and result held 10 cycles.
//    Then out_ready=1 together with a back-to-back frame -> no result lost or duplicated.
// T6 reset_n pulsed mid-frame (after nibble F) -> outputs 0 immediately; next 5,3 frame gives crc_ok=1.
//    With CRC_CHECK_STATS_EN defined: stat_good/stat_bad match the taken result counts; stat_clr zeroes both.

Source files
------------

// File: rtl/crc_4_check.sv
// rtl/crc_4_check.sv - nibble-serial CRC checker, G = x^3+1, per-frame pass/fail with length policing
// Optional saturating good/bad frame counters when CRC_CHECK_STATS_EN is defined.
module crc_4_check #(
  parameter int MAX_NIBBLES = 64,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic [2:0] rem_out
`ifdef CRC_CHECK_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad,
  input  logic        stat_clr
`endif
);

  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DROP} state_t;

  state_t           state;
  logic [2:0]       rem;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             take;
  logic [2:0]       rem_next;
  logic             frame_ok;

  // Shift one bit in MSB-first; x^3 folds back to 1 because G = x^3+1.
  function automatic logic [2:0] div_nibble(input logic [2:0] r, input logic [3:0] d);
    logic [2:0] t;
    t = r;
    for (int i = 3; i >= 0; i--) begin
      t = {t[1:0], d[i]} ^ {2'b00, t[2]};
    end
    return t;
  endfunction

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    accept   = in_valid && in_ready;
    take     = out_valid && out_ready;
    rem_next = div_nibble((state == IDLE) ? 3'b000 : rem, in_data);
    frame_ok = (rem_next == 3'b000) && !in_data[3];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rem       <= 3'b000;
      count     <= '0;
      out_valid <= 1'b0;
      crc_ok    <= 1'b0;
      crc_err   <= 1'b0;
      len_err   <= 1'b0;
      rem_out   <= 3'b000;
    end else begin
      if (take) out_valid <= 1'b0;
      if (accept) begin
        case (state)
          IDLE: begin
            rem   <= rem_next;
            count <= CNT_W'(1);
            if (in_last) begin
              out_valid <= 1'b1;
              crc_ok    <= 1'b0;
              crc_err   <= 1'b1;
              len_err   <= 1'b1;
              rem_out   <= 3'b000;
            end else begin
              state <= RUN;
            end
          end
          RUN: begin
            rem   <= rem_next;
            count <= count + CNT_W'(1);
            if (in_last) begin
              out_valid <= 1'b1;
              crc_ok    <= frame_ok;
              crc_err   <= !frame_ok;
              len_err   <= 1'b0;
              rem_out   <= rem_next;
              state     <= IDLE;
            end else if (count == LIMIT_M1) begin
              // Frame already at the limit and still no trailer: report once, discard the rest.
              out_valid <= 1'b1;
              crc_ok    <= 1'b0;
              crc_err   <= 1'b1;
              len_err   <= 1'b1;
              rem_out   <= 3'b000;
              state     <= DROP;
            end
          end
          DROP: begin
            if (in_last) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CRC_CHECK_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_good <= 16'h0000;
      stat_bad  <= 16'h0000;
    end else if (stat_clr) begin
      stat_good <= 16'h0000;
      stat_bad  <= 16'h0000;
    end else if (take) begin
      if (crc_ok && stat_good != 16'hFFFF) stat_good <= stat_good + 16'h0001;
      if (crc_err && stat_bad != 16'hFFFF) stat_bad <= stat_bad + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_crc_4_check.sv
// tb/tb_crc_4_check.sv - randomized self-checking bench for crc_4_check against a frame-level model
// Optional CRC_CHECK_STATS_EN adds counter checks.
module tb_crc_4_check;
  localparam int MAX = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = 4'h0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       crc_ok, crc_err, len_err;
  logic [2:0] rem_out;
`ifdef CRC_CHECK_STATS_EN
  logic [15:0] stat_good, stat_bad;
  logic        stat_clr = 1'b0;
`endif

  crc_4_check #(.MAX_NIBBLES(MAX), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err), .rem_out(rem_out)
`ifdef CRC_CHECK_STATS_EN
    , .stat_good(stat_good), .stat_bad(stat_bad), .stat_clr(stat_clr)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_taken = 0;
  int good_taken = 0;
  int bad_taken = 0;
  logic [5:0] last_res;
  logic       rnd_rdy = 1'b0;
  logic       gaps = 1'b0;

  logic [3:0] frm[$];
  logic [5:0] exp_q[$];
  logic       dropping = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of the whole frame polynomial mod x^3+1: x^p contributes to bit p mod 3.
  function automatic logic [2:0] frame_rem(input logic [3:0] q[$]);
    logic [2:0] r;
    int n;
    r = 3'b000;
    n = q.size();
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++)
        if (q[i][b]) r[((n - 1 - i) * 4 + b) % 3] ^= 1'b1;
    return r;
  endfunction

  function automatic logic [3:0] gen_trailer(input logic [3:0] payload[$]);
    logic [3:0] tmp[$];
    tmp = payload;
    tmp.push_back(4'h0);
    return {1'b0, frame_rem(tmp)};
  endfunction

  task automatic model_accept(input logic [3:0] d, input logic l);
    logic [2:0] r;
    logic ok;
    if (dropping) begin
      if (l) dropping = 1'b0;
    end else begin
      frm.push_back(d);
      if (l) begin
        if (frm.size() == 1) exp_q.push_back(6'b011000);
        else begin
          r  = frame_rem(frm);
          ok = (r == 3'b000) && !d[3];
          exp_q.push_back({ok, !ok, 1'b0, r});
        end
        frm.delete();
      end else if (frm.size() == MAX) begin
        exp_q.push_back(6'b011000);
        frm.delete();
        dropping = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] e;
    if (reset_n) begin
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("result", {crc_ok, crc_err, len_err, rem_out}, e);
          if (e[5]) good_taken++;
          if (e[4]) bad_taken++;
        end
        last_res = {crc_ok, crc_err, len_err, rem_out};
        n_taken++;
      end
      if (in_valid && in_ready) model_accept(in_data, in_last);
    end
  end

  always @(posedge clk) if (rnd_rdy) begin
    #1;
    out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 after the nibble is accepted.
  task automatic send(input logic [3:0] d, input logic l);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int w = 0; w < 200 && !got; w++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    if (!got) check("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [3:0] q[$]);
    for (int i = 0; i < q.size(); i++) send(q[i], i == q.size() - 1);
  endtask

  task automatic wait_taken(input int target);
    for (int c = 0; c < 300 && n_taken < target; c++) @(posedge clk);
    check("wait_taken", n_taken >= target, 1);
    #1;
  endtask

  task automatic expect_frame(input string tag, input logic [3:0] q[$], input logic [5:0] e);
    int base;
    base = n_taken;
    send_frame(q);
    wait_taken(base + 1);
    check(tag, last_res, e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_flags"}, {crc_ok, crc_err, len_err, rem_out}, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [3:0] q[$];
    logic [3:0] pay[$];
    int base, len, sel;

    #3 check_reset_outputs("reset");
`ifdef CRC_CHECK_STATS_EN
    check("reset_stats", {stat_good, stat_bad}, 0);
`endif
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    q = '{4'h5, 4'h3};             expect_frame("t1_good", q, 6'b100000);
    q = '{4'hF, 4'h0, 4'h2};       expect_frame("t2_corrupt", q, 6'b010001);
    q = '{4'hF, 4'h0, 4'h3};       expect_frame("t2_good", q, 6'b100000);
    q = '{4'h5, 4'hB};             expect_frame("t3_bit3", q, 6'b010001);
    q = '{4'h5};                   expect_frame("t4_single", q, 6'b011000);

    base = n_taken;
    q.delete();
    for (int i = 0; i < MAX + 3; i++) q.push_back(4'($urandom_range(0, 15)));
    send_frame(q);
    wait_taken(base + 1);
    repeat (4) @(posedge clk);
    #1;
    check("t4_one_len_result", n_taken, base + 1);
    check("t4_len_err", last_res, 6'b011000);
    q = '{4'h5, 4'h3};             expect_frame("t4_after_drop", q, 6'b100000);

    // Backpressure: hold a result, then release it alongside a back-to-back frame.
    base = n_taken;
    out_ready = 1'b0;
    q = '{4'h5, 4'h3};
    send_frame(q);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_stall_ready", in_ready, 0);
      check("t5_held", {out_valid, crc_ok, crc_err, len_err, rem_out}, 7'b1100000);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_frame(q);
    wait_taken(base + 2);
    repeat (3) @(posedge clk);
    #1;
    check("t5_count", n_taken, base + 2);

    // Reset in the middle of a frame.
    send(4'hF, 1'b0);
    reset_n = 1'b0;
    frm.delete(); exp_q.delete(); dropping = 1'b0;
    good_taken = 0; bad_taken = 0;
    #1 check_reset_outputs("t6_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    q = '{4'h5, 4'h3};             expect_frame("t6_after_reset", q, 6'b100000);

    // Randomized frames with random gaps and random consumer backpressure.
    rnd_rdy = 1'b1;
    gaps = 1'b1;
    for (int f = 0; f < 300; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 1;
      else if (sel == 1) len = MAX - 1 + $urandom_range(0, 4);
      else len = $urandom_range(2, 8);
      pay.delete();
      for (int i = 0; i < len - 1; i++) pay.push_back(4'($urandom_range(0, 15)));
      q = pay;
      if ($urandom_range(0, 9) < 7) q.push_back(gen_trailer(pay));
      else q.push_back(4'($urandom_range(0, 15)));
      send_frame(q);
    end
    rnd_rdy = 1'b0;
    gaps = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);

`ifdef CRC_CHECK_STATS_EN
    check("stat_good", stat_good, good_taken);
    check("stat_bad", stat_bad, bad_taken);
    stat_clr = 1'b1;
    @(posedge clk); #1 stat_clr = 1'b0;
    check("stat_clr", {stat_good, stat_bad}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
